// File: rtl/lcd_16207_timing_ctrl.sv
// Avalon-MM slave that turns each access into a timed HD44780 bus cycle
// (setup, E pulse, hold, optional post-write gap), stalling the master via waitrequest.
module lcd_16207_timing_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 2000,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP} state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((T_GAP > 0) ? T_GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic             is_rd_q, is_rd_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             e_q, lcd_rs_q, lcd_rw_q, oe_q;
  logic [7:0]       readdata_q;
  logic             capture;
  logic             active_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    rs_d        = rs_q;
    rw_d        = rw_q;
    is_rd_d     = is_rd_q;
    wdata_d     = wdata_q;
    capture     = 1'b0;
    waitrequest = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (read || write) begin
          // a simultaneous read+write is a write; only true reads update readdata
          state_d = SETUP;
          rs_d    = address[1];
          rw_d    = address[0];
          is_rd_d = !write;
          wdata_d = writedata;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          capture = is_rd_q;
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          waitrequest = 1'b0;
          cnt_d       = '0;
          state_d     = (!rw_q && (T_GAP > 0)) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin registers follow the next state so they change together with it.
  assign active_d = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b1;
      is_rd_q    <= 1'b0;
      wdata_q    <= 8'h00;
      e_q        <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b1;
      oe_q       <= 1'b0;
      readdata_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      is_rd_q  <= is_rd_d;
      wdata_q  <= wdata_d;
      e_q      <= (state_d == PULSE);
      lcd_rs_q <= active_d ? rs_d : 1'b0;
      lcd_rw_q <= active_d ? rw_d : 1'b1;
      oe_q     <= active_d && !rw_d;
      if (capture) begin
        readdata_q <= LCD_data;
      end
    end
  end

  assign LCD_E    = e_q;
  assign LCD_RS   = lcd_rs_q;
  assign LCD_RW   = lcd_rw_q;
  assign LCD_data = oe_q ? wdata_q : 8'hzz;
  assign readdata = readdata_q;

endmodule
